// File: rtl/el2_uart_rx_pkg.sv
// el2_uart_rx_pkg: shared types and constants for the EL2 UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity state).
package el2_uart_rx_pkg;

   localparam int unsigned DATA_BITS   = 8;
   localparam logic        RX_SYNC_RST = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY    = 3'd3,
`endif
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_e;

endpackage

// File: rtl/el2_uart_rx_fifo.sv
// el2_uart_rx_fifo: synchronous FIFO with registered head and extended-pointer
// full/empty detection. A push on a full FIFO is accepted only if a pop
// frees a slot in the same cycle.
module el2_uart_rx_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned PW    = AW + 1
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [PW-1:0]    level,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign rdata   = head_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Next memory/pointer state; head is taken from the post-write memory so a
   // push into an empty FIFO is visible as the head one cycle later.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      head_d = mem_d[rd_ptr_d[AW-1:0]];
   end

   // Storage, pointers and registered head.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/el2_uart_rx.sv
// el2_uart_rx: 8-bit UART receiver (1 start, 8 data, 1 stop, LSB first) with
// receive FIFO, valid/ready pop interface and sticky error flags.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit before stop).
module el2_uart_rx
   import el2_uart_rx_pkg::*;
#(
   parameter  int unsigned CLKS_PER_BIT = 16,
   parameter  int unsigned FIFO_DEPTH   = 16,
   localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             en,
   input  logic             rx,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [LVL_W-1:0] fifo_level,
   output logic             overrun,
   output logic             frame_err,
   output logic             parity_err,
   input  logic             err_clr
);

   localparam int unsigned    CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     LAST_IDX  = 3'(DATA_BITS - 1);

   logic                 rx_s1_q, rx_s2_q, rx_sync;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 expiry, push, frame_evt, overrun_evt, pop;
   logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
   logic                 parity_evt;
`endif

   assign rx_sync = rx_s2_q;
   assign expiry  = (cnt_q == '0);

   // Two-flop synchronizer for the asynchronous serial input.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rx_s1_q <= RX_SYNC_RST;
         rx_s2_q <= RX_SYNC_RST;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
      end
   end

   // Frame FSM next state; push is combinational so the byte enters the FIFO
   // on the stop-sample edge itself.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d  = par_bad_q;
      parity_evt = 1'b0;
`endif
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_sync) begin
                  state_d = ST_START;
                  cnt_d   = HALF_LOAD;
               end
            end
            ST_START: begin
               if (!expiry) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (rx_sync) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  cnt_d   = FULL_LOAD;
                  idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
               end
            end
            ST_DATA: begin
               if (!expiry) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  shreg_d[idx_q] = rx_sync;
                  cnt_d          = FULL_LOAD;
                  if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (!expiry) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  if (^{shreg_q, rx_sync}) begin
                     parity_evt = 1'b1;
                     par_bad_d  = 1'b1;
                  end
                  state_d = ST_STOP;
                  cnt_d   = FULL_LOAD;
               end
            end
`endif
            ST_STOP: begin
               if (!expiry) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                  push = ~par_bad_q;
`else
                  push = 1'b1;
`endif
                  state_d = ST_IDLE;
               end else begin
                  frame_evt = 1'b1;
                  state_d   = ST_WAIT_HIGH;
               end
            end
            ST_WAIT_HIGH: begin
               if (rx_sync) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pop         = rx_ready & ~fifo_empty;
   assign overrun_evt = push & fifo_full & ~pop;

   // Sticky flags: a set event outranks err_clr in the same cycle.
   always_comb begin
      frame_err_d = frame_evt   ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
      overrun_d   = overrun_evt ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_evt ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
`endif
   end

   // FSM, bit counter, shift register and flag registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   el2_uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .push    (push),
      .wdata   (shreg_q),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level),
      .rdata   (rx_data)
   );

   assign rx_valid = ~fifo_empty;

endmodule

// File: doc/el2_uart_rx.md
# el2_uart_rx

Synthesizable 8-bit UART receiver with a receive FIFO for the EL2 SoC UART subsystem. It consumes the serial stream that a UART TX pin produces (idle-high, LSB-first, 1 start, 8 data, 1 stop). It is the hardware counterpart of the bench's serial terminal and is instantiated on RsRx-side pins. Received bytes are buffered and exposed to the bus-side logic through a valid/ready pop interface with sticky error flags.

## Interface
- CLKS_PER_BIT, 16: HCLK cycles per serial bit; even, ≥ 8.
- FIFO_DEPTH, 16: RX FIFO entries; power of 2, ≥ 2.
- HCLK  in  1  system clock; all logic on its rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- en  in  1  receiver enable.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  FIFO head byte; reset 0x00.
- rx_valid  out  1  FIFO non-empty; reset 0.
- rx_ready  in  1  pop head when rx_valid & rx_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held; reset 0.
- overrun  out  1  sticky, byte dropped on full FIFO; reset 0.
- frame_err  out  1  sticky, stop bit sampled 0; reset 0.
- parity_err  out  1  sticky, parity mismatch; reset 0; tied 0 without UART_RX_PARITY_EN.
- err_clr  in  1  clears all sticky flags in that cycle; a set event in the same cycle wins.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All FSM sampling uses the synchronized value.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: when en=1 and the synchronized rx is 0, go to START and load the bit counter with CLKS_PER_BIT/2−1.
- START: at counter expiry, sample rx.
  - rx=1: false start; return to IDLE with no flags.
  - rx=0: go to DATA; reload the counter with CLKS_PER_BIT−1; bit index = 0.
- DATA: at each expiry, shift the sample into bit[index], LSB first. After bit 7, go to PARITY or STOP.
- PARITY: sample one bit; even parity over 8 data bits + parity bit must be 0, else set parity_err. Then go to STOP.
- STOP: sample at expiry.
  - 1: push the byte unless a parity error occurred in this frame; go to IDLE.
  - 0: set frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until the synchronized rx is 1, then go to IDLE. This blocks re-triggering during a break.
- Push when full: the byte is dropped, overrun is set, and FIFO contents are unchanged. If a pop occurs in the same cycle, the push is accepted and no overrun occurs.
- Push and pop in the same non-full, non-empty cycle: level unchanged, head advances.
- Pop when empty: ignored.
- en=0: the FSM is forced to IDLE the next cycle; a partial byte is discarded. FIFO contents, the pop interface and the flags remain operational.
- FIFO pointers have $clog2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and the remaining bits are equal.

## Timing
- Edge E0: first rising edge at which the synchronized rx reads 0; the FSM enters START.
- Sample times relative to E0: start sample at E0+CLKS_PER_BIT/2; data bit k at E0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT; stop bit at E0+CLKS_PER_BIT/2+9·CLKS_PER_BIT (+CLKS_PER_BIT with parity).
- Push happens on the stop-sample edge. rx_valid, rx_data and fifo_level update in the following cycle.
- Total latency, raw rx low to rx_valid: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. For CLKS_PER_BIT=16 this is 155 cycles.
- rx_data is registered FIFO head. After a pop, the next entry is visible in the following cycle.
- Reset assertion mid-frame returns all state to reset values immediately. The FIFO is emptied and the partial frame is lost.

## Configuration
- UART_RX_PARITY_EN defined: an even-parity bit is expected between D7 and stop, the PARITY state exists, and parity_err is live.
- Undefined: frame is 8N1, PARITY state is absent, parity_err is constant 0.

## Structure
- Package el2_uart_rx_pkg:
  - FSM state enum.
  - DATA_BITS = 8.
  - Synchronizer reset value.
- Sub-module el2_uart_rx_fifo: synchronous FIFO parameterized by width and depth, with push/pop/full/empty/level and registered head.
- The FSM, bit counter and synchronizer stay in the top module.

## Test plan
- Send 0x55 at CLKS_PER_BIT=16, rx_ready=0 → rx_valid=1 after 155 cycles, rx_data=0x55, fifo_level=1, no flags.
- Drive rx low for 4 cycles then high → START rejects the frame; fifo_level stays 0, no flags.
- Send 0xA3 with stop bit 0, then hold rx low for 40 cycles, then send 0x12 → frame_err=1, only 0x12 is pushed, fifo_level=1.
- Send 17 bytes 0x00..0x10 with no pops → overrun=1, fifo_level=16, head 0x00. Pop with rx_ready=1 → 0x00..0x0F in order. Pulse err_clr → overrun=0.
- Deassert en during bit 3 of 0x7E, reassert, send 0x81 → only 0x81 is received. Also assert HRESETn=0 mid-frame → all outputs return to reset values.
- With UART_RX_PARITY_EN, send 0xA5 with parity 1 (wrong) → parity_err=1, byte discarded. Send 0xA5 with parity 0 → 0xA5 is pushed.
